// File: rtl/intf_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial frame transmitter.
package intf_serializer_pkg;

   // Widest frame the serializer can carry.
   localparam int MAX_W = 32;

   // Line phases of one frame, plus the idle/accept phase.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      GAP    = 3'd4
   } state_t;

   // Even parity over a word whose unused upper bits are already zero.
   function automatic logic even_parity(input logic [MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/intf_serializer_if.sv
// Serial line bundle; FOO carries the frame width into the serializer.
interface test_if #(parameter int FOO = 8) ();

   logic data;

   // Driver side of the serial line.
   modport mp     (output data);
   modport master (output data);
   // Receiver / observer side of the serial line.
   modport slave  (input data);

endinterface

// File: rtl/intf_serializer_bitcount.sv
// Loadable down-counter with zero flag, shared by the DATA and GAP phases.
module ser_bitcount #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt_r;

   // Load has priority; decrement saturates at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {CW{1'b0}})) begin
         cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/intf_serializer.sv
// Parallel-to-serial frame transmitter: start bit, W data bits LSB first,
// optional even parity, then an idle gap. Width comes from the interface.
module intf_serializer
   import intf_serializer_pkg::*;
#(
   parameter int PARITY_EN = 1,
   parameter int IDLE_GAP  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   test_if.mp          intf,
   output logic        frame,
   output logic [7:0]  frames_sent
);

   localparam int W  = intf.FOO;
   localparam int BW = $clog2(W + 1);
   // The shared counter must also hold IDLE_GAP-1 (up to 14).
   localparam int CW = (BW > 4) ? BW : 4;

   localparam logic [MAX_W-1:0] W_MASK    = {MAX_W{1'b1}} >> (MAX_W - W);
   localparam logic [CW-1:0]    DATA_LOAD = CW'(W - 1);
   localparam logic [CW-1:0]    GAP_LOAD  = CW'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

   state_t            state_r;
   logic [MAX_W-1:0]  shift_r;
   logic              parity_r;
   logic              data_r;
   logic              frame_r;
   logic              ready_r;
   logic [7:0]        frames_r;

   logic              cnt_load_s;
   logic              cnt_dec_s;
   logic [CW-1:0]     cnt_val_s;
   logic              cnt_zero_s;
   logic [MAX_W-1:0]  word_s;

   assign word_s = in_data & W_MASK;

   // Counter control: load bit count on START, gap length at frame end,
   // count down through DATA and GAP.
   always_comb begin
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      cnt_val_s  = {CW{1'b0}};
      case (state_r)
         START: begin
            cnt_load_s = 1'b1;
            cnt_val_s  = DATA_LOAD;
         end
         DATA: begin
            if (!cnt_zero_s) begin
               cnt_dec_s = 1'b1;
            end else if (PARITY_EN == 0) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = GAP_LOAD;
            end else begin
               cnt_dec_s = 1'b0;
            end
         end
         PARITY: begin
            cnt_load_s = 1'b1;
            cnt_val_s  = GAP_LOAD;
         end
         GAP: begin
            cnt_dec_s = 1'b1;
         end
         default: begin
            cnt_dec_s = 1'b0;
         end
      endcase
   end

   ser_bitcount #(.CW(CW)) u_bitcount (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load_s),
      .dec      (cnt_dec_s),
      .load_val (cnt_val_s),
      .zero     (cnt_zero_s)
   );

   // Frame FSM; every output is set one cycle ahead from its own register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         shift_r  <= {MAX_W{1'b0}};
         parity_r <= 1'b0;
         data_r   <= 1'b0;
         frame_r  <= 1'b0;
         ready_r  <= 1'b0;
         frames_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               data_r  <= 1'b0;
               frame_r <= 1'b0;
               if (ready_r && in_valid) begin
                  shift_r  <= word_s;
                  parity_r <= even_parity(word_s);
                  ready_r  <= 1'b0;
                  data_r   <= 1'b1;
                  frame_r  <= 1'b1;
                  state_r  <= START;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            START: begin
               data_r  <= shift_r[0];
               shift_r <= {1'b0, shift_r[MAX_W-1:1]};
               state_r <= DATA;
            end
            DATA: begin
               if (!cnt_zero_s) begin
                  data_r  <= shift_r[0];
                  shift_r <= {1'b0, shift_r[MAX_W-1:1]};
               end else if (PARITY_EN != 0) begin
                  data_r  <= parity_r;
                  state_r <= PARITY;
               end else begin
                  frames_r <= frames_r + 8'd1;
                  data_r   <= 1'b0;
                  frame_r  <= 1'b0;
                  if (IDLE_GAP > 0) begin
                     state_r <= GAP;
                  end else begin
                     ready_r <= 1'b1;
                     state_r <= IDLE;
                  end
               end
            end
            PARITY: begin
               frames_r <= frames_r + 8'd1;
               data_r   <= 1'b0;
               frame_r  <= 1'b0;
               if (IDLE_GAP > 0) begin
                  state_r <= GAP;
               end else begin
                  ready_r <= 1'b1;
                  state_r <= IDLE;
               end
            end
            GAP: begin
               if (cnt_zero_s) begin
                  ready_r <= 1'b1;
                  state_r <= IDLE;
               end else begin
                  state_r <= GAP;
               end
            end
            default: begin
               data_r  <= 1'b0;
               frame_r <= 1'b0;
               ready_r <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign intf.data   = data_r;
   assign frame       = frame_r;
   assign in_ready    = ready_r;
   assign frames_sent = frames_r;

endmodule

// File: tb/tb_intf_serializer.sv
// Randomized bench for intf_serializer: two instances (parity+gap 2, and
// no parity/no gap) checked every cycle against a queue-based line model.
module tb_intf_serializer;

   localparam int W = 5;

   typedef struct packed {
      logic       frame;
      logic       data;
      logic       last;
      logic [7:0] idx;
   } ent_t;

   logic             clk;
   logic [1:0]       rst_n;
   logic [1:0][31:0] in_data;
   logic [1:0]       in_valid;
   logic [1:0]       in_ready;
   logic [1:0]       frame;
   logic [1:0][7:0]  fs;

   test_if #(.FOO(W)) if0 ();
   test_if #(.FOO(W)) if1 ();

   intf_serializer #(.PARITY_EN(1), .IDLE_GAP(2)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .intf(if0.mp), .frame(frame[0]), .frames_sent(fs[0])
   );

   intf_serializer #(.PARITY_EN(0), .IDLE_GAP(0)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .intf(if1.mp), .frame(frame[1]), .frames_sent(fs[1])
   );

   int   n_cmp = 0;
   int   n_bad = 0;

   ent_t        exp_q [2][$];
   logic [31:0] dir_q [2][$];
   logic [7:0]  exp_fs [2];
   int          total [2];
   int          rst_cnt [2];
   int          mode [2];
   logic        arm_abort [2];
   logic        wrap_chk [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int par_en(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   function automatic int gap_len(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   function automatic logic line(input int d);
      return (d == 0) ? if0.data : if1.data;
   endfunction

   // Expected line schedule for one accepted word.
   task automatic push_frame(input int d, input logic [31:0] raw);
      logic [W-1:0] word;
      logic         p;
      word = raw[W-1:0];
      p = 1'b0;
      exp_q[d].push_back('{frame: 1'b1, data: 1'b1, last: 1'b0, idx: 8'd0});
      for (int i = 0; i < W; i++) begin
         p = p ^ word[i];
         exp_q[d].push_back('{frame: 1'b1, data: word[i],
                              last: (i == W - 1) && (par_en(d) == 0), idx: 8'(i + 1)});
      end
      if (par_en(d) != 0)
         exp_q[d].push_back('{frame: 1'b1, data: p, last: 1'b1, idx: 8'(W + 1)});
      for (int g = 0; g < gap_len(d); g++)
         exp_q[d].push_back('{frame: 1'b0, data: 1'b0, last: 1'b0, idx: 8'd255});
   endtask

   // One sampling point (negedge) for instance d: check, then drive next inputs.
   task automatic tick(input int d);
      ent_t e;
      logic er;
      logic busy;
      string s;
      s = $sformatf("d%0d", d);
      if (!rst_n[d]) begin
         check_eq({s, "_rst_ready"}, 32'(in_ready[d]), 32'd0);
         check_eq({s, "_rst_frame"}, 32'(frame[d]), 32'd0);
         check_eq({s, "_rst_data"}, 32'(line(d)), 32'd0);
         check_eq({s, "_rst_fs"}, 32'(fs[d]), 32'd0);
         exp_q[d].delete();
         exp_fs[d] = 8'd0;
         total[d] = 0;
         in_valid[d] = 1'b0;
         rst_cnt[d]--;
         if (rst_cnt[d] <= 0) rst_n[d] = 1'b1;
         return;
      end
      busy = (exp_q[d].size() != 0);
      if (busy) begin
         e = exp_q[d].pop_front();
         er = 1'b0;
      end else begin
         e = '{frame: 1'b0, data: 1'b0, last: 1'b0, idx: 8'd255};
         er = 1'b1;
      end
      check_eq({s, "_ready"}, 32'(in_ready[d]), 32'(er));
      check_eq({s, "_frame"}, 32'(frame[d]), 32'(e.frame));
      check_eq({s, "_data"}, 32'(line(d)), 32'(e.data));
      check_eq({s, "_fs"}, 32'(fs[d]), 32'(exp_fs[d]));
      if (wrap_chk[d]) begin
         check_eq({s, "_wrap256"}, 32'(fs[d]), 32'd0);
         wrap_chk[d] = 1'b0;
      end
      if (e.last) begin
         exp_fs[d] = exp_fs[d] + 8'd1;
         total[d]++;
         if (total[d] == 256) wrap_chk[d] = 1'b1;
      end
      if (arm_abort[d] && busy && e.idx == 8'd3) begin
         rst_n[d] = 1'b0;
         #1;
         check_eq({s, "_abort_data"}, 32'(line(d)), 32'd0);
         check_eq({s, "_abort_frame"}, 32'(frame[d]), 32'd0);
         check_eq({s, "_abort_fs"}, 32'(fs[d]), 32'd0);
         arm_abort[d] = 1'b0;
         rst_cnt[d] = 1;
         in_valid[d] = 1'b0;
         return;
      end
      in_data[d] = $urandom();
      if (dir_q[d].size() != 0) begin
         in_valid[d] = 1'b1;
         in_data[d] = dir_q[d][0];
      end else if (mode[d] == 1) begin
         in_valid[d] = 1'b1;
      end else begin
         in_valid[d] = 1'($urandom_range(0, 1));
      end
      if (er && in_valid[d]) begin
         if (dir_q[d].size() != 0) void'(dir_q[d].pop_front());
         push_frame(d, in_data[d]);
      end
   endtask

   initial begin
      rst_n = 2'b00;
      in_valid = 2'b00;
      in_data = '0;
      for (int d = 0; d < 2; d++) begin
         exp_fs[d] = 8'd0;
         total[d] = 0;
         rst_cnt[d] = 3;
         wrap_chk[d] = 1'b0;
      end
      // Instance 0: first frame is aborted by reset in DATA bit 2,
      // then the reference word 10110 with parity.
      arm_abort[0] = 1'b1;
      mode[0] = 0;
      dir_q[0].push_back($urandom());
      dir_q[0].push_back(32'h0000_0016);
      // Instance 1: 00001 first, then back-to-back frames past the 8-bit wrap.
      arm_abort[1] = 1'b0;
      mode[1] = 1;
      dir_q[1].push_back(32'h0000_0001);

      for (int c = 0; c < 2400; c++) begin
         @(negedge clk);
         mode[0] = (c >= 300 && c < 700) ? 1 : 0;
         if (total[1] > 260) mode[1] = 0;
         for (int d = 0; d < 2; d++) tick(d);
      end
      check_eq("d1_frames_total", 32'(total[1] > 256), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/intf_serializer.md
INTF_SERIALIZER -- requirements
Module: intf_serializer

Interface
REQ-001 SHALL have parameter PARITY_EN, default 1: 1 appends an even-parity bit after the data bits, 0 omits it.
REQ-002 SHALL have parameter IDLE_GAP, default 1: number of cycles, 0..15, with line idle after each frame.
REQ-003 SHALL take frame width W from the connected interface's FOO parameter at elaboration (localparam W = intf.FOO); W ranges 1..32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_data, input, 32 bits: parallel word; only bits [W-1:0] are used.
REQ-007 SHALL have port in_valid, input, 1 bit: producer offers in_data.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-009 SHALL have port intf, modport test_if.mp: the block drives intf.data, 1 bit, as the serial line.
REQ-010 SHALL have port frame, output, 1 bit: high while a start, data or parity bit is on intf.data.
REQ-011 SHALL have port frames_sent, output, 8 bits: count of completed frames.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY and GAP.
REQ-013 SHALL drive in_ready=1 only in IDLE; a transfer occurs on a rising edge where in_valid && in_ready.
REQ-014 SHALL capture in_data[W-1:0] into a shift register on transfer and move IDLE->START.
REQ-015 SHALL drive START for 1 cycle with intf.data=1 and frame=1; the start bit appears the cycle after the transfer.
REQ-016 SHALL drive DATA for exactly W cycles, LSB first, with frame=1, using a bit counter of width $clog2(W+1).
REQ-017 SHALL move DATA->PARITY when PARITY_EN=1; PARITY lasts 1 cycle, intf.data = XOR of the captured W bits, frame=1.
REQ-018 SHALL skip PARITY when PARITY_EN=0.
REQ-019 SHALL move to GAP for IDLE_GAP cycles with intf.data=0, frame=0; GAP is skipped when IDLE_GAP=0.
REQ-020 SHALL then return to IDLE.
REQ-021 SHALL drive intf.data=0 and frame=0 in IDLE.
REQ-022 SHALL increment frames_sent on the last frame=1 cycle of each frame and wrap 255->0.
REQ-023 SHALL keep the captured word unaffected by in_data or in_valid changes after capture.
REQ-024 SHALL ignore in_valid while in_ready=0; nothing is queued.
REQ-025 SHALL, with in_valid held high, send back-to-back frames separated by exactly IDLE_GAP+1 cycles with frame=0 (GAP plus the IDLE accept cycle).
REQ-026 SHALL give frame length W+1+PARITY_EN cycles.
REQ-027 SHALL register every output; there is no combinational path from in_valid to any output.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state=IDLE, intf.data=0, frame=0, in_ready=0, frames_sent=0, counters=0 and shift register=0.
REQ-029 SHALL make in_ready rise on the first clk edge after rst_n deasserts.
REQ-030 SHALL abort a frame cleanly on reset mid-frame: no partial increment of frames_sent, line low immediately.

Structure
REQ-031 SHALL declare the state enum and the constant MAX_W=32 in shared package intf_serializer_pkg.
REQ-032 SHALL split out one sub-module, ser_bitcount, holding the parameterised down-counter with load, decrement and zero flag; it is used for both DATA and GAP.
REQ-033 SHALL carry W only through the interface parameter, with no duplicate top-level width parameter.

Verification (W=5 via test_if #(.FOO(5)))
REQ-034 SHALL cover a single frame: in_data=5'b10110 with PARITY_EN=1 -> intf.data = 1,0,1,1,0,1, parity 1 over 7 frame cycles, then frames_sent=1.
REQ-035 SHALL cover back-to-back frames: in_valid held high, IDLE_GAP=2 -> exactly 3 cycles with frame=0 between frames, and in_ready pulses 1 cycle per frame.
REQ-036 SHALL cover no-parity, no-gap operation: PARITY_EN=0, IDLE_GAP=0, in_data=5'b00001 -> frame lasts 6 cycles, then 1 IDLE cycle, then the next start bit.
REQ-037 SHALL cover reset mid-frame: rst_n low in DATA bit 2 -> intf.data=0, frame=0 and frames_sent unchanged at 0 within the same cycle; normal operation after release.
REQ-038 SHALL cover counter wrap: 256 frames -> frames_sent reads 0.
REQ-039 SHALL cover input change after capture: in_data changed mid-frame -> the transmitted bits still match the captured word.
